// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes, flag bundle and flag-write masks for the condition path.
package cond_pkg;
   typedef enum logic [3:0] {
      EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
   } cond_t;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;
   localparam logic [1:0] FLAGW_NZ = 2'b10;
   localparam logic [1:0] FLAGW_CV = 2'b01;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-field check against a flag set.
import cond_pkg::*;
module cond_eval (
   input  cond_t  cond,
   input  flags_t flags,
   output logic   cond_ex
);
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         EQ: cond_ex = flags.z;
         NE: cond_ex = ~flags.z;
         CS: cond_ex = flags.c;
         CC: cond_ex = ~flags.c;
         MI: cond_ex = flags.n;
         PL: cond_ex = ~flags.n;
         VS: cond_ex = flags.v;
         VC: cond_ex = ~flags.v;
         HI: cond_ex = flags.c & ~flags.z;
         LS: cond_ex = ~flags.c | flags.z;
         GE: cond_ex = flags.n == flags.v;
         LT: cond_ex = flags.n != flags.v;
         GT: cond_ex = ~flags.z & (flags.n == flags.v);
         LE: cond_ex = flags.z | (flags.n != flags.v);
         AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag registers, condition-gated write enables and saturating squash counter.
import cond_pkg::*;
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             instr_valid,
   input  logic [3:0]       cond,
   input  logic [3:0]       alu_flags,
   input  logic [1:0]       flag_w,
   input  logic             pcs,
   input  logic             reg_w,
   input  logic             mem_w,
   input  logic             no_write,
   output logic             cond_ex,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_write,
   output logic             negative,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic [CNT_W-1:0] squash_cnt
);
   flags_t flags;
   logic   pass;
   logic   live;
   cond_eval u_eval (.cond(cond_t'(cond)), .flags(flags), .cond_ex(cond_ex));
   assign live      = instr_valid & ~flush;
   assign pass      = cond_ex & live;
   // Reset is asynchronous, so enables are masked directly rather than waiting for a clock
   assign pc_src    = pcs & pass & ~rst;
   assign reg_write = reg_w & ~no_write & pass & ~rst;
   assign mem_write = mem_w & pass & ~rst;
   assign {negative, zero, cout, overflow} = flags;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags      <= '0;
         squash_cnt <= '0;
      end else if (en) begin
         if (pass && |(flag_w & FLAGW_NZ)) {flags.n, flags.z} <= alu_flags[3:2];
         if (pass && |(flag_w & FLAGW_CV)) {flags.c, flags.v} <= alu_flags[1:0];
         if (live && !cond_ex && squash_cnt != {CNT_W{1'b1}}) squash_cnt <= squash_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed + randomized stimulus, reference model feeding a scoreboard queue.
module tb_cond_flag_unit;
   logic clk = 0;
   logic rst = 1, en = 0, flush = 0, instr_valid = 0;
   logic [3:0] cond = 0, alu_flags = 0;
   logic [1:0] flag_w = 0;
   logic pcs = 0, reg_w = 0, mem_w = 0, no_write = 0;
   logic cond_ex, pc_src, reg_write, mem_write, negative, zero, cout, overflow;
   logic [15:0] squash_cnt;
   logic cond_ex3, pc_src3, reg_write3, mem_write3, n3, z3, c3, v3;
   logic [2:0] squash_cnt3;

   cond_flag_unit dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .instr_valid(instr_valid), .cond(cond),
      .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
      .no_write(no_write), .cond_ex(cond_ex), .pc_src(pc_src), .reg_write(reg_write),
      .mem_write(mem_write), .negative(negative), .zero(zero), .cout(cout),
      .overflow(overflow), .squash_cnt(squash_cnt));

   cond_flag_unit #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .instr_valid(instr_valid), .cond(cond),
      .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
      .no_write(no_write), .cond_ex(cond_ex3), .pc_src(pc_src3), .reg_write(reg_write3),
      .mem_write(mem_write3), .negative(n3), .zero(z3), .cout(c3),
      .overflow(v3), .squash_cnt(squash_cnt3));

   always #5 clk = ~clk;

   typedef struct {
      logic       cex, pcs, rw, mw;
      logic [3:0] fl;
      int         cnt, cnt3;
      string      tag;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_flags = 0;
   int         m_cnt = 0, m_cnt3 = 0;
   int         compared = 0, mismatched = 0;
   bit         done = 0;

   // Reference: even codes name a base predicate, odd codes are its inverse; 1111 never passes.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, b;
      {n, z, cy, v} = f;
      b = (c[3:1] == 0) ? z : (c[3:1] == 1) ? cy : (c[3:1] == 2) ? n : (c[3:1] == 3) ? v :
          (c[3:1] == 4) ? (cy && !z) : (c[3:1] == 5) ? (n == v) :
          (c[3:1] == 6) ? (!z && n == v) : 1'b1;
      return (c == 4'hF) ? 1'b0 : b ^ c[0];
   endfunction

   task automatic step(input logic r, input logic e, input logic fl, input logic vld,
                       input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                       input logic p, input logic rwi, input logic mwi, input logic nw,
                       input string tag);
      exp_t x;
      logic ok;
      @(posedge clk);
      #1;
      rst = r; en = e; flush = fl; instr_valid = vld; cond = c; alu_flags = af;
      flag_w = fw; pcs = p; reg_w = rwi; mem_w = mwi; no_write = nw;
      if (r) begin
         m_flags = 0; m_cnt = 0; m_cnt3 = 0;
      end
      x.cex = ref_cond(c, m_flags);
      ok    = x.cex && vld && !fl && !r;
      x.pcs = p && ok;
      x.rw  = rwi && !nw && ok;
      x.mw  = mwi && ok;
      x.fl  = m_flags;
      x.cnt = m_cnt;
      x.cnt3 = m_cnt3;
      x.tag = tag;
      q.push_back(x);
      if (!r && e && !fl && vld) begin
         if (x.cex) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
         end else begin
            m_cnt  = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
            m_cnt3 = (m_cnt3 == 7) ? m_cnt3 : m_cnt3 + 1;
         end
      end
   endtask

   task automatic chk(input string nm, input string tag, input int act, input int req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s/%s: got %0d expected %0d at %0t", tag, nm, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            x = q.pop_front();
            chk("cond_ex", x.tag, int'(cond_ex), int'(x.cex));
            chk("pc_src", x.tag, int'(pc_src), int'(x.pcs));
            chk("reg_write", x.tag, int'(reg_write), int'(x.rw));
            chk("mem_write", x.tag, int'(mem_write), int'(x.mw));
            chk("flags", x.tag, int'({negative, zero, cout, overflow}), int'(x.fl));
            chk("squash_cnt", x.tag, int'(squash_cnt), x.cnt);
            chk("squash_cnt3", x.tag, int'(squash_cnt3), x.cnt3);
            chk("flags3", x.tag, int'({n3, z3, c3, v3}), int'(x.fl));
         end
      end
   end

   initial begin : driver
      repeat (2) @(posedge clk);
      // flags to 1111 and five squashes, then reset mid-stream
      step(0,1,0,1, 4'hE, 4'hF, 2'b11, 0,1,0,0, "t1_set");
      for (int i = 0; i < 5; i++) step(0,1,0,1, 4'hF, 4'h0, 2'b00, 0,1,0,0, "t1_sq");
      step(0,1,0,1, 4'hE, 4'h0, 2'b00, 1,1,1,0, "t1_pre");
      step(1,1,0,1, 4'hE, 4'hF, 2'b11, 1,1,1,0, "t1_rst");
      // AL writes Z, then EQ/NE observe it
      step(0,1,0,1, 4'hE, 4'b0100, 2'b11, 0,1,0,0, "t2_al");
      step(0,1,0,1, 4'h0, 4'h0, 2'b00, 0,1,0,0, "t2_eq");
      step(0,1,0,1, 4'h1, 4'h0, 2'b00, 0,1,0,0, "t2_ne");
      // clear Z, then a failing EQ must not write flags
      step(0,1,0,1, 4'hE, 4'b0000, 2'b11, 0,0,0,0, "t3_clr");
      step(0,1,0,1, 4'h0, 4'hF, 2'b11, 0,1,1,0, "t3_eq");
      step(0,1,0,1, 4'hE, 4'h0, 2'b00, 0,0,0,0, "t3_chk");
      // N=0,Z=1 then CV-only write
      step(0,1,0,1, 4'hE, 4'b0100, 2'b11, 0,0,0,0, "t4_nz");
      step(0,1,0,1, 4'hE, 4'b1010, 2'b01, 0,0,0,1, "t4_cv");
      step(0,1,0,1, 4'h8, 4'h0, 2'b00, 0,0,0,0, "t4_hi");
      step(0,1,0,1, 4'h9, 4'h0, 2'b00, 0,0,0,0, "t4_ls");
      // stall, then flush
      step(0,0,0,1, 4'hE, 4'hF, 2'b11, 1,1,1,0, "t5_stall");
      step(0,0,0,1, 4'hF, 4'hF, 2'b11, 1,1,1,0, "t5_stall_sq");
      step(0,1,1,1, 4'hE, 4'hF, 2'b11, 1,1,1,0, "t5_flush");
      step(0,1,0,1, 4'hE, 4'h0, 2'b00, 0,0,0,0, "t5_chk");
      // saturation on the 3-bit counter
      step(1,0,0,0, 4'h0, 4'h0, 2'b00, 0,0,0,0, "t6_rst");
      for (int i = 0; i < 9; i++) step(0,1,0,1, 4'hF, 4'h0, 2'b00, 0,0,0,0, "t6_sat");
      step(0,1,0,1, 4'hE, 4'h0, 2'b00, 0,0,0,0, "t6_chk");
      // full cond x NZCV sweep
      for (int f = 0; f < 16; f++)
         for (int c = 0; c < 16; c++) begin
            step(0,1,0,1, 4'hE, 4'(f), 2'b11, 0,0,0,0, "sweep_set");
            step(0,1,0,1, 4'(c), 4'h0, 2'b00, 1,1,1,0, "sweep");
         end
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(63) == 0), ($urandom_range(3) != 0), ($urandom_range(7) == 0),
              ($urandom_range(5) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand");
      repeat (3) @(negedge clk);
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
